dnn_mlp_seq: RTL and testbench

- Parametrised two-layer fully connected inference engine: N_IN inputs, N_HID ReLU hidden neurons, N_OUT linear outputs.
- Successor to the fixed 4-4-2 DNN datapath.
- A bank of N_LANE dot-product lanes is time-multiplexed over hidden neurons, then over output neurons.
- Adds a valid/ready handshake with output backpressure, selectable hidden saturation, and exposed hidden activations.

---
 rtl/dnn_pkg.sv | 34 +++
 rtl/dnn_mlp_seq_if.sv | 26 ++
 rtl/dnn_mac_lane.sv | 30 +++
 rtl/dnn_mlp_seq.sv | 168 ++++++++++++++++
 tb/tb_dnn_mlp_seq.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/dnn_pkg.sv
// Shared types and helpers for the sequential two-layer MLP engine.
package dnn_pkg;

    typedef enum logic [1:0] {IDLE, L1, L2, DONE} dnn_seq_state_t;

    // Number of lane beats needed to cover n neurons with lanes lanes.
    function automatic int ceil_div(input int n, input int lanes);
        return (n + lanes - 1) / lanes;
    endfunction

    // Hidden activation: ReLU, then either clamp or wrap positive overflow.
    // Wrapping keeps the low h_w bits; a wrapped value with its top bit set
    // reads as negative and is therefore zeroed.
    function automatic logic signed [63:0] relu_sat(input logic signed [63:0] sum,
                                                    input bit sat, input int h_w);
        logic signed [63:0] max_v;
        logic signed [63:0] r;
        max_v = (64'sd1 <<< (h_w - 1)) - 64'sd1;
        if (sum < 0) begin
            r = '0;
        end else if (sum > max_v) begin
            if (sat) begin
                r = max_v;
            end else begin
                r = sum & ((64'sd1 <<< h_w) - 64'sd1);
                if (r[h_w-1]) r = '0;
            end
        end else begin
            r = sum;
        end
        return r;
    endfunction

endpackage

// File: rtl/dnn_mlp_seq_if.sv
// Handshake and operand/result bus of the sequential MLP engine.
interface dnn_mlp_seq_if #(
    parameter int N_IN  = 4,
    parameter int N_HID = 4,
    parameter int N_OUT = 2,
    parameter int X_W   = 7,
    parameter int W_W   = 5,
    parameter int H_W   = 13
);
    localparam int O_W = H_W + W_W + $clog2(N_HID);

    logic                         in_valid;
    logic                         in_ready;
    logic [N_IN*X_W-1:0]          x;
    logic [N_IN*N_HID*W_W-1:0]    w_l1;
    logic [N_HID*N_OUT*W_W-1:0]   w_l2;
    logic                         out_valid;
    logic                         out_ready;
    logic [N_OUT*O_W-1:0]         y;
    logic [N_HID*H_W-1:0]         hid;

    modport master (output in_valid, x, w_l1, w_l2, out_ready,
                    input  in_ready, out_valid, y, hid);
    modport slave  (input  in_valid, x, w_l1, w_l2, out_ready,
                    output in_ready, out_valid, y, hid);
endinterface

// File: rtl/dnn_mac_lane.sv
// Combinational signed dot product with a per-term enable mask.
module dnn_mac_lane #(
    parameter int N_TERM = 4,
    parameter int A_W    = 13,
    parameter int B_W    = 5,
    parameter int S_W    = 20
) (
    input  logic [N_TERM*A_W-1:0]  i_a,
    input  logic [N_TERM*B_W-1:0]  i_b,
    input  logic [N_TERM-1:0]      i_en,
    output logic signed [S_W-1:0]  o_sum
);
    logic signed [A_W-1:0] w_a;
    logic signed [B_W-1:0] w_b;
    logic signed [S_W-1:0] w_acc;

    // Sum of sign-extended products of the enabled terms.
    always_comb begin
        w_acc = '0;
        w_a   = '0;
        w_b   = '0;
        for (int t = 0; t < N_TERM; t++) begin
            w_a = $signed(i_a[t*A_W +: A_W]);
            w_b = $signed(i_b[t*B_W +: B_W]);
            if (i_en[t]) w_acc = w_acc + S_W'(w_a) * S_W'(w_b);
        end
    end

    assign o_sum = w_acc;
endmodule

// File: rtl/dnn_mlp_seq.sv
// Two-layer MLP engine: N_LANE MAC lanes time-shared over hidden, then output neurons.
module dnn_mlp_seq
    import dnn_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int N_HID  = 4,
    parameter int N_OUT  = 2,
    parameter int N_LANE = 2,
    parameter int X_W    = 7,
    parameter int W_W    = 5,
    parameter int H_W    = 13,
    parameter int SAT    = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    dnn_mlp_seq_if.slave bus
);
    localparam int O_W    = H_W + W_W + $clog2(N_HID);
    localparam int A_W    = X_W + W_W + $clog2(N_IN);
    localparam int B1     = ceil_div(N_HID, N_LANE);
    localparam int B2     = ceil_div(N_OUT, N_LANE);
    localparam int BMAX   = (B1 > B2) ? B1 : B2;
    localparam int BEAT_W = (BMAX > 1) ? $clog2(BMAX) : 1;
    localparam int N_T    = (N_IN > N_HID) ? N_IN : N_HID;
    localparam int OP_W   = (X_W > H_W) ? X_W : H_W;
    localparam int S_W    = (A_W > O_W) ? A_W : O_W;

    dnn_seq_state_t              r_state, w_state_nxt;
    logic [BEAT_W-1:0]           r_beat, w_beat_nxt;
    logic                        w_capture, w_in_ready, w_out_valid;

    logic [N_IN*X_W-1:0]         r_x;
    logic [N_IN*N_HID*W_W-1:0]   r_w1;
    logic [N_HID*N_OUT*W_W-1:0]  r_w2;
    logic [N_HID*H_W-1:0]        r_hwork, w_h_next, r_hid;
    logic [N_OUT*O_W-1:0]        r_yacc, w_y_next, r_y;
    logic signed [S_W-1:0]       w_sum [N_LANE];

    for (genvar k = 0; k < N_LANE; k++) begin : g_lane
        logic [N_T*OP_W-1:0] w_a;
        logic [N_T*W_W-1:0]  w_b;
        logic [N_T-1:0]      w_en;
        int                  w_n;

        // Route captured inputs (L1) or working hidden values (L2) to this lane.
        always_comb begin
            w_a  = '0;
            w_b  = '0;
            w_en = '0;
            w_n  = int'(r_beat) * N_LANE + k;
            if (r_state == L1 && w_n < N_HID) begin
                for (int t = 0; t < N_IN; t++) begin
                    w_a[t*OP_W +: OP_W] = OP_W'($signed(r_x[t*X_W +: X_W]));
                    w_b[t*W_W +: W_W]   = r_w1[(w_n*N_IN + t)*W_W +: W_W];
                    w_en[t]             = 1'b1;
                end
            end else if (r_state == L2 && w_n < N_OUT) begin
                for (int t = 0; t < N_HID; t++) begin
                    w_a[t*OP_W +: OP_W] = OP_W'($signed(r_hwork[t*H_W +: H_W]));
                    w_b[t*W_W +: W_W]   = r_w2[(w_n*N_HID + t)*W_W +: W_W];
                    w_en[t]             = 1'b1;
                end
            end
        end

        dnn_mac_lane #(.N_TERM(N_T), .A_W(OP_W), .B_W(W_W), .S_W(S_W)) u_lane (
            .i_a   (w_a),
            .i_b   (w_b),
            .i_en  (w_en),
            .o_sum (w_sum[k])
        );
    end

    // Merge this beat's lane results into the working hidden/output vectors.
    always_comb begin
        w_h_next = r_hwork;
        w_y_next = r_yacc;
        for (int k = 0; k < N_LANE; k++) begin
            if (int'(r_beat) * N_LANE + k < N_HID)
                w_h_next[(int'(r_beat) * N_LANE + k)*H_W +: H_W] =
                    H_W'(relu_sat(64'(w_sum[k]), SAT != 0, H_W));
            if (int'(r_beat) * N_LANE + k < N_OUT)
                w_y_next[(int'(r_beat) * N_LANE + k)*O_W +: O_W] = O_W'(w_sum[k]);
        end
    end

    // Next-state, beat counter and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_capture   = 1'b0;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = L1;
                    w_beat_nxt  = '0;
                end
            end
            L1: begin
                if (r_beat == BEAT_W'(B1 - 1)) begin
                    w_state_nxt = L2;
                    w_beat_nxt  = '0;
                end else begin
                    w_beat_nxt = r_beat + BEAT_W'(1);
                end
            end
            L2: begin
                if (r_beat == BEAT_W'(B2 - 1)) begin
                    w_state_nxt = DONE;
                    w_beat_nxt  = '0;
                end else begin
                    w_beat_nxt = r_beat + BEAT_W'(1);
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                w_in_ready  = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        w_capture   = 1'b1;
                        w_state_nxt = L1;
                        w_beat_nxt  = '0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, beat and published results; results update only on entry to DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_beat  <= '0;
            r_hid   <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            if (r_state == L2 && w_state_nxt == DONE) begin
                r_hid <= r_hwork;
                r_y   <= w_y_next;
            end
        end
    end

    // Operand capture and working accumulators; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_x  <= bus.x;
            r_w1 <= bus.w_l1;
            r_w2 <= bus.w_l2;
        end
        if (r_state == L1) r_hwork <= w_h_next;
        if (r_state == L2) r_yacc  <= w_y_next;
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.y         = r_y;
    assign bus.hid       = r_hid;
endmodule

// File: tb/tb_dnn_mlp_seq.sv
// Directed bench for dnn_mlp_seq: default wrap, default clamp and a 4-5-3 / 2-lane build.
module tb_dnn_mlp_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_bad = 0;
    int   lat;
    int   c_w1 [5] = '{1, 2, -1, 4, 5};

    always #5 clk = ~clk;

    dnn_mlp_seq_if ifa ();
    dnn_mlp_seq_if ifb ();
    dnn_mlp_seq_if #(.N_HID(5), .N_OUT(3)) ifc ();

    dnn_mlp_seq #(.SAT(0)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    dnn_mlp_seq #(.SAT(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    dnn_mlp_seq #(.N_HID(5), .N_OUT(3), .N_LANE(2)) u_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    task automatic chk(input string tag, input longint got, input longint exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    function automatic longint ya(input int o);
        return longint'($signed(ifa.y[o*20 +: 20]));
    endfunction
    function automatic longint ha(input int h);
        return longint'(ifa.hid[h*13 +: 13]);
    endfunction
    function automatic longint yc(input int o);
        return longint'($signed(ifc.y[o*21 +: 21]));
    endfunction
    function automatic longint hc(input int h);
        return longint'(ifc.hid[h*13 +: 13]);
    endfunction

    task automatic set_a(input int x0, input int x1, input int x2, input int x3,
                         input int w1, input int w2);
        ifa.x = {7'(x3), 7'(x2), 7'(x1), 7'(x0)};
        for (int j = 0; j < 16; j++) ifa.w_l1[j*5 +: 5] = 5'(w1);
        for (int j = 0; j < 8; j++)  ifa.w_l2[j*5 +: 5] = 5'(w2);
    endtask

    task automatic scramble(input int sel);
        case (sel)
            0: begin ifa.in_valid = 1'b0; ifa.x = ~ifa.x; ifa.w_l1 = ~ifa.w_l1; ifa.w_l2 = ~ifa.w_l2; end
            1: begin ifb.in_valid = 1'b0; ifb.x = ~ifb.x; ifb.w_l1 = ~ifb.w_l1; ifb.w_l2 = ~ifb.w_l2; end
            default: begin ifc.in_valid = 1'b0; ifc.x = ~ifc.x; ifc.w_l1 = ~ifc.w_l1; ifc.w_l2 = ~ifc.w_l2; end
        endcase
    endtask

    function automatic logic ov(input int sel);
        return (sel == 0) ? ifa.out_valid : (sel == 1) ? ifb.out_valid : ifc.out_valid;
    endfunction

    // Called at a negedge with the DUT ready; counts edges from acceptance to out_valid.
    task automatic run(input int sel, output int lat_o);
        case (sel)
            0: ifa.in_valid = 1'b1;
            1: ifb.in_valid = 1'b1;
            default: ifc.in_valid = 1'b1;
        endcase
        @(posedge clk);
        #1;
        scramble(sel);
        lat_o = 0;
        @(negedge clk);
        while (!ov(sel) && lat_o < 40) begin
            @(negedge clk);
            lat_o++;
        end
    endtask

    initial begin
        ifa.in_valid = 1'b0; ifa.out_ready = 1'b1; ifa.x = '0; ifa.w_l1 = '0; ifa.w_l2 = '0;
        ifb.in_valid = 1'b0; ifb.out_ready = 1'b1; ifb.x = '0; ifb.w_l1 = '0; ifb.w_l2 = '0;
        ifc.in_valid = 1'b0; ifc.out_ready = 1'b1; ifc.x = '0; ifc.w_l1 = '0; ifc.w_l2 = '0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", longint'(ifa.in_ready), 1);
        chk("rst_out_valid", longint'(ifa.out_valid), 0);
        chk("rst_y", longint'(ifa.y), 0);
        chk("rst_hid", longint'(ifa.hid), 0);
        rst_n = 1'b1;

        // basic vector: hid = 10 each, y = 4*10*2
        set_a(1, 2, 3, 4, 1, 2);
        run(0, lat);
        chk("lat_a", lat, 3);
        chk("t1_hid0", ha(0), 10);
        chk("t1_hid3", ha(3), 10);
        chk("t1_y0", ya(0), 80);
        chk("t1_y1", ya(1), 80);
        @(negedge clk);
        chk("t1_idle_ov", longint'(ifa.out_valid), 0);
        chk("t1_y_hold", ya(0), 80);

        // negative output weights
        set_a(1, 2, 3, 4, 1, -16);
        run(0, lat);
        chk("t1b_y0", ya(0), -640);
        chk("t1b_y1", ya(1), -640);
        @(negedge clk);

        // negative sums clip to zero
        set_a(-64, -64, -64, -64, 1, 2);
        run(0, lat);
        chk("t2_hid0", ha(0), 0);
        chk("t2_y0", ya(0), 0);
        @(negedge clk);

        // sum 3840 stays in range
        set_a(-64, -64, -64, -64, -15, 2);
        run(0, lat);
        chk("t2_hid_inrange", ha(1), 3840);
        chk("t2_y_inrange", ya(1), 30720);
        @(negedge clk);

        // sum 4096 wraps to a negative pattern -> 0
        set_a(-64, -64, -64, -64, -16, 2);
        run(0, lat);
        chk("t2_wrap_hid0", ha(0), 0);
        chk("t2_wrap_hid3", ha(3), 0);
        chk("t2_wrap_y0", ya(0), 0);
        @(negedge clk);

        // clamp build: 4096 saturates to 4095
        ifb.x = {4{7'(-64)}};
        for (int j = 0; j < 16; j++) ifb.w_l1[j*5 +: 5] = 5'(-16);
        for (int j = 0; j < 8; j++)  ifb.w_l2[j*5 +: 5] = 5'(2);
        run(1, lat);
        chk("lat_b", lat, 3);
        chk("sat_hid0", longint'(ifb.hid[0 +: 13]), 4095);
        chk("sat_hid2", longint'(ifb.hid[26 +: 13]), 4095);
        chk("sat_y0", longint'($signed(ifb.y[0 +: 20])), 32760);
        @(negedge clk);

        // backpressure in DONE
        ifa.out_ready = 1'b0;
        set_a(1, 2, 3, 4, 1, 2);
        run(0, lat);
        chk("bp_lat", lat, 3);
        set_a(5, 5, 5, 5, 1, 2);
        ifa.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_ov", longint'(ifa.out_valid), 1);
            chk("bp_in_ready", longint'(ifa.in_ready), 0);
            chk("bp_y0", ya(0), 80);
            chk("bp_hid1", ha(1), 10);
        end
        ifa.out_ready = 1'b1;
        #1;
        chk("bp_in_ready_rel", longint'(ifa.in_ready), 1);
        @(posedge clk);
        #1;
        scramble(0);
        @(negedge clk);
        chk("bp_ov_fall", longint'(ifa.out_valid), 0);
        chk("bp_y_keep", ya(0), 80);
        lat = 0;
        while (!ifa.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_lat2", lat, 3);
        chk("bp2_hid2", ha(2), 20);
        chk("bp2_y0", ya(0), 160);
        @(negedge clk);

        // reset during L2
        set_a(1, 2, 3, 4, 1, 2);
        ifa.in_valid = 1'b1;
        @(posedge clk);
        #1;
        scramble(0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_ov", longint'(ifa.out_valid), 0);
        chk("mrst_in_ready", longint'(ifa.in_ready), 1);
        chk("mrst_y", longint'(ifa.y), 0);
        chk("mrst_hid", longint'(ifa.hid), 0);
        set_a(1, 2, 3, 4, 2, 1);
        run(0, lat);
        chk("mrst_lat", lat, 3);
        chk("mrst_hid0", ha(0), 20);
        chk("mrst_y1", ya(1), 80);
        @(negedge clk);

        // 4-5-3 build with 2 lanes: partial last beats in both layers
        ifc.x = {7'(4), 7'(3), 7'(2), 7'(1)};
        for (int h = 0; h < 5; h++)
            for (int i = 0; i < 4; i++) ifc.w_l1[(h*4 + i)*5 +: 5] = 5'(c_w1[h]);
        for (int o = 0; o < 3; o++)
            for (int h = 0; h < 5; h++)
                ifc.w_l2[(o*5 + h)*5 +: 5] = 5'((o == 0) ? 1 : (o == 1) ? h - 2 : -3);
        run(2, lat);
        chk("c_lat", lat, 5);
        chk("c_hid0", hc(0), 10);
        chk("c_hid1", hc(1), 20);
        chk("c_hid2", hc(2), 0);
        chk("c_hid3", hc(3), 40);
        chk("c_hid4", hc(4), 50);
        chk("c_y0", yc(0), 120);
        chk("c_y1", yc(1), 100);
        chk("c_y2", yc(2), -360);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
